// File: rtl/shift_issue_queue_pkg.sv
// Shared types for the shift issue queue: op-codes, the queued command record
// and the op legality check.
package shift_issue_queue_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    // Tag field is sized for the widest supported tag; instances use the low TAG_W bits.
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic [7:0]           data;
        logic [2:0]           amt;
        logic [2:0]           op;
        logic [MAX_TAG_W-1:0] tag;
    } cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/shift_issue_queue_core.sv
// Combinational 8-bit barrel-shift core; illegal ops pass data through and flag err.
module shift_issue_queue_core
    import shift_issue_queue_pkg::*;
(
    input  logic [7:0] data,
    input  logic [2:0] amt,
    input  logic [2:0] op,
    output logic [7:0] res,
    output logic       err
);

    logic [15:0] rot_s;

    // Select the shift result for the requested operation
    always_comb begin
        res   = data;
        err   = ~is_legal_op(op);
        rot_s = {data, data};
        case (op)
            OP_SLL: res = data << amt;
            OP_SRL: res = data >> amt;
            OP_SRA: res = $signed(data) >>> amt;
            OP_ROR: begin
                rot_s = {data, data} >> amt;
                res   = rot_s[7:0];
            end
            OP_ROL: begin
                rot_s = {data, data} << amt;
                res   = rot_s[15:8];
            end
            default: res = data;
        endcase
    end

endmodule

// File: rtl/shift_issue_queue.sv
// Buffered issue stage: command FIFO feeding the barrel-shift core, result
// registered into a valid/ready output stage (2-cycle latency, 1 result/cycle).
module shift_issue_queue
    import shift_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic [2:0]                 in_amt,
    input  logic [2:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    cmd_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    cmd_t             in_cmd_s;
    cmd_t             head_s;
    logic [7:0]       core_res_s;
    logic             core_err_s;
    logic             push_s;
    logic             pop_s;

    // Readiness comes from the count register only; no full-pass-through.
    assign in_ready = rst_n & (count_r != CNT_W'(DEPTH));
    assign count    = count_r;
    assign push_s   = in_valid & in_ready;
    assign pop_s    = (count_r != CNT_W'(0)) & (~out_valid | out_ready);
    assign head_s   = mem_r[rd_ptr_r];

    // Pack the incoming command into the storage record
    always_comb begin
        in_cmd_s      = '0;
        in_cmd_s.data = in_data;
        in_cmd_s.amt  = in_amt;
        in_cmd_s.op   = in_op;
        in_cmd_s.tag  = MAX_TAG_W'(in_tag);
    end

    shift_issue_queue_core u_core (
        .data (head_s.data),
        .amt  (head_s.amt),
        .op   (head_s.op),
        .res  (core_res_s),
        .err  (core_err_s)
    );

    // FIFO storage write; entries need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            mem_r[wr_ptr_r] <= in_cmd_s;
        end
    end

    // Pointers, occupancy and output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
                out_valid <= 1'b1;
                out_data  <= core_res_s;
                out_tag   <= head_s.tag[TAG_W-1:0];
                out_err   <= core_err_s;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_shift_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [7:0]       in_data, out_data;
    logic [2:0]       in_amt, in_op;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [2:0]       count;

    int n_cmp = 0;
    int n_bad = 0;

    shift_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       d;
        logic [TAG_W-1:0] t;
        logic             e;
    } res_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic [2:0] amt;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    res_t             mq[$];
    logic             m_ov;
    logic [7:0]       m_od;
    logic [TAG_W-1:0] m_ot;
    logic             m_oe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift result from arithmetic on the integer value of the operand
    function automatic res_t ref_result(input logic [7:0] d8, input logic [2:0] a3,
                                        input logic [2:0] op, input logic [TAG_W-1:0] t);
        res_t r;
        int d = int'(d8);
        int p = 1 << a3;
        int v;
        case (op)
            3'd0:    v = (d * p) % 256;
            3'd1:    v = d / p;
            3'd2:    v = d / p + ((d >= 128) ? (256 - 256 / p) : 0);
            3'd3:    v = (d % p) * (256 / p) + d / p;
            3'd4:    v = (d * p) % 256 + d / (256 / p);
            default: v = d;
        endcase
        r.d = v[7:0];
        r.t = t;
        r.e = (op > 3'd4);
        return r;
    endfunction

    task automatic model_update();
        bit   push, pop;
        res_t e;
        if (!rst_n) begin
            mq.delete();
            m_ov = 1'b0; m_od = 8'h00; m_ot = '0; m_oe = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            push = in_valid && (mq.size() < DEPTH);
            pop  = (mq.size() != 0) && (!m_ov || out_ready);
            if (pop) begin
                e = mq.pop_front();
                m_ov = 1'b1; m_od = e.d; m_ot = e.t; m_oe = e.e;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (push) mq.push_back(ref_result(in_data, in_amt, in_op, in_tag));
        end
    endtask

    task automatic model_check();
        chk("in_ready", 32'(in_ready), 32'(rst_n && (mq.size() < DEPTH)));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_tag", 32'(out_tag), 32'(m_ot));
        chk("out_err", 32'(out_err), 32'(m_oe));
    endtask

    // One clock: advance the model from pre-edge inputs, then compare at negedge
    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic [2:0] op, input logic [TAG_W-1:0] t);
        in_valid = v; in_data = d; in_amt = a; in_op = op; in_tag = t;
    endtask

    vec_t tbl[9];
    int   ri;

    initial begin
        tbl[0] = '{3'b000, 8'h96, 3'd3, 8'hB0, 1'b0};
        tbl[1] = '{3'b001, 8'h96, 3'd3, 8'h12, 1'b0};
        tbl[2] = '{3'b010, 8'h96, 3'd3, 8'hF2, 1'b0};
        tbl[3] = '{3'b011, 8'h96, 3'd3, 8'hD2, 1'b0};
        tbl[4] = '{3'b100, 8'h96, 3'd3, 8'hB4, 1'b0};
        tbl[5] = '{3'b011, 8'h96, 3'd0, 8'h96, 1'b0};
        tbl[6] = '{3'b100, 8'h96, 3'd0, 8'h96, 1'b0};
        tbl[7] = '{3'b110, 8'h5A, 3'd2, 8'h5A, 1'b1};
        tbl[8] = '{3'b001, 8'h5A, 3'd2, 8'h16, 1'b0};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        step(); step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed table, back-to-back with out_ready high
        ri = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 9) drive(1'b1, tbl[i].d, tbl[i].amt, tbl[i].op, TAG_W'(i));
            else       drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
            step();
            if (i == 0) chk("latency_n1", 32'(out_valid), 32'd0);
            if (i == 1) chk("latency_n2", 32'(out_valid), 32'd1);
            if (out_valid && ri < 9) begin
                chk("tbl_data", 32'(out_data), 32'(tbl[ri].exp_d));
                chk("tbl_err", 32'(out_err), 32'(tbl[ri].exp_e));
                chk("tbl_tag", 32'(out_tag), 32'(ri));
                ri++;
            end
        end
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        step();
        chk("tbl_all_results", 32'(ri), 32'd9);

        // Backpressure: 6 offered, 5 accepted, first result held
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h11 * i), 3'(i), 3'(i % 5), TAG_W'(i + 1));
            step();
        end
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_tag", 32'(out_tag), 32'd1);
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        step();
        chk("bp_hold_tag2", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC3, 3'(i), 3'd3, TAG_W'(i + 7));
            step();
        end
        flush = 1'b1;
        drive(1'b1, 8'hEE, 3'd1, 3'd0, 4'hE);
        step();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 8'h81, 3'd1, 3'd2, 4'h5);
        step();
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        step();
        chk("post_flush_data", 32'(out_data), 32'hC0);
        step();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h3C, 3'd2, 3'd4, TAG_W'(i + 3));
            step();
        end
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready_comb", 32'(in_ready), 32'd0);
        step();
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 3'($urandom),
                  TAG_W'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 3'd0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_issue_queue.md
Name: shift_issue_queue

Overview:
- Buffered issue stage wrapped around the 8-bit combinational barrel-shift core.
- Accepts shift commands (data, amount, op, tag) over a valid/ready handshake and holds them in a small FIFO.
- Drives the FIFO head into the shift core and registers the result into an output stage with its own valid/ready handshake.
- Gives the datapath a fixed 2-cycle latency and 1 result/cycle throughput.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >= 2)
TAG_W, 4, width of the opaque tag carried with each command

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of FIFO and output stage
in_valid  in  1  command valid
in_ready  out  1  command accepted when in_valid & in_ready
in_data  in  8  operand
in_amt  in  3  shift amount 0..7
in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101-111 illegal
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  8  shifted result
out_tag  out  TAG_W  tag of the result
out_err  out  1  1 = illegal op; data passed through unchanged
count  out  $clog2(DEPTH+1)  FIFO occupancy; excludes the output stage

Behaviour:
- Reset (rst_n low at an edge):
  - count = 0, rd/wr pointers = 0.
  - out_valid = 0, out_data = 0, out_tag = 0, out_err = 0.
  - in_ready is forced 0 combinationally while rst_n is low.
  - Reset mid-operation discards all queued commands and any held result.
- in_ready = (count < DEPTH). When full, in_ready stays low even if a pop occurs that cycle; there is no full-pass-through.
- Push: in_valid & in_ready writes {data, amt, op, tag} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop condition: count != 0 and (!out_valid or out_ready).
- On pop:
  - Output registers load the shift-core result for the head entry, plus its tag and err.
  - out_valid is set to 1 and rd_ptr advances, wrapping modulo DEPTH.
- Consume without pop: out_valid & out_ready with count == 0 clears out_valid. out_data, out_tag and out_err hold their last values.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- Latency:
  - A command accepted at edge N becomes FIFO head in cycle N+1.
  - It is loaded into the output registers at edge N+1, so out_valid is high in cycle N+2.
  - No bypass path.
- Throughput: with out_ready held high, one result per cycle sustained.
- Output stability: while out_valid & !out_ready, out_data, out_tag and out_err hold constant.
- Shift semantics (8-bit, amt 0..7):
  - SLL/SRL zero-fill.
  - SRA replicates bit 7.
  - ROR/ROL rotate.
  - Any op with amt 0 returns data unchanged.
- Illegal op (101-111): out_data = in_data, out_err = 1. Legal ops give out_err = 0.
- Flush:
  - Takes priority over push and pop in the same cycle; a concurrent push is dropped.
  - Next cycle: count = 0, pointers = 0, out_valid = 0.
- in_ready, count and out_* are driven from registers only. in_ready is derived from the count register, so there is no combinational path from out_ready to in_ready.

Decomposition:
- Shared package holds:
  - the op-code localparams: OP_SLL = 3'b000, OP_SRL = 3'b001, OP_SRA = 3'b010, OP_ROR = 3'b011, OP_ROL = 3'b100;
  - a packed command struct {data[7:0], amt[2:0], op[2:0], tag};
  - the is_legal_op function.
- One sub-module: the existing combinational barrel-shift core, instantiated once and driven from the FIFO head.
- The FIFO stays inline; no separate FIFO module.

Test Plan:
1. out_ready = 1; push in_data = 8'h96, in_amt = 3 with each legal op back-to-back → out_data 8'hB0 (SLL), 8'h12 (SRL), 8'hF2 (SRA), 8'hD2 (ROR), 8'hB4 (ROL); first out_valid 2 cycles after first accept, then one result per cycle, tags in order.
2. in_data = 8'h96, in_amt = 0, ops ROR and ROL → out_data 8'h96 both times, out_err = 0.
3. out_ready = 0; push 6 commands continuously → 5 accepted (1 in output stage, 4 in FIFO), count = 4, in_ready low. Output holds the first result stable. Raise out_ready → 5 results drained in order, tags intact.
4. in_op = 3'b110, in_data = 8'h5A, in_amt = 2 → out_data 8'h5A, out_err = 1. Next legal command → out_err = 0.
5. Queue 3 commands with out_ready = 0, then assert flush with in_valid = 1 → next cycle count = 0, out_valid = 0, flushed-cycle push not delivered. Later pushes flow normally from pointer 0.
6. Drop rst_n for one edge with 2 commands queued and out_valid = 1 → all outputs at reset values, in_ready = 0 during reset. After release: in_ready = 1, no stale results emitted.
